// File: rtl/sram_bus_pkg.sv
// Shared definitions for the cache_data_* SRAM-like bus: size encodings,
// byte-lane mask and merge helpers used by the caches and the memory responder.
package sram_bus_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Response queue payload; age is tracked separately inside the queue.
  typedef struct packed {
    logic              wr;
    logic [DATA_W-1:0] rdata;
  } resp_t;

  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] offs);
    logic [3:0] m;
    case (size)
      SIZE_BYTE: m = 4'b0001 << offs;
      SIZE_HALF: m = offs[1] ? 4'b1100 : 4'b0011;
      default:   m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_word,
                                                    input logic [DATA_W-1:0] new_word,
                                                    input logic [3:0]        mask);
    logic [DATA_W-1:0] w;
    for (int i = 0; i < 4; i++) begin
      w[8*i +: 8] = mask[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return w;
  endfunction

endpackage

// File: rtl/sram_like_mem_responder_resp_queue.sv
// In-order response FIFO; every entry carries a saturating age so the head
// can be released exactly LATENCY cycles after it was pushed.
module resp_queue
  import sram_bus_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned LATENCY = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  resp_t push_data,
  input  logic  pop,
  output resp_t head,
  output logic  head_done,
  output logic  full,
  output logic  empty
);

  localparam int unsigned AGE_W = $clog2(LATENCY + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  resp_t            data_q [DEPTH];
  logic [AGE_W-1:0] age_q  [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(p + 1'b1);
  endfunction

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign head      = data_q[rptr_q];
  assign head_done = (age_q[rptr_q] == AGE_W'(LATENCY));

  always_ff @(posedge clk) begin
    if (push) data_q[wptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (age_q[i] != AGE_W'(LATENCY)) age_q[i] <= AGE_W'(age_q[i] + 1'b1);
      end
      if (push) begin
        age_q[wptr_q] <= AGE_W'(1);
        wptr_q        <= ptr_inc(wptr_q);
      end
      if (pop) rptr_q <= ptr_inc(rptr_q);
      case ({push, pop})
        2'b10:   count_q <= CNT_W'(count_q + 1'b1);
        2'b01:   count_q <= CNT_W'(count_q - 1'b1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_mem_responder.sv
// Memory-side responder for the cache_data_* SRAM-like bus: word RAM accessed on
// accept, in-order data_ok after a fixed latency, optional LFSR backpressure.
module sram_like_mem_responder
  import sram_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned OUTSTANDING = 2,
  parameter bit          STALL_EN    = 1'b0,
  parameter logic [3:0]  LFSR_SEED   = 4'b1000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        addr_ok,
  output logic        data_ok
);

  localparam int unsigned RAM_DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_W-1:0]     mem [RAM_DEPTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic [3:0]            lfsr_q;
  logic                  accept;
  logic                  q_full, q_empty, head_done;
  resp_t                 push_data, head;
  logic                  addr_hi_unused;

  assign idx            = addr[ADDR_WIDTH+1:2];
  assign addr_hi_unused = ^addr[31:ADDR_WIDTH+2];

  // Full is not relieved by a same-cycle pop, so LATENCY == OUTSTANDING stalls one cycle in three.
  assign addr_ok = req & resetn & ~q_full & (~STALL_EN | lfsr_q[0]);
  assign accept  = addr_ok;

  assign push_data.wr    = wr;
  assign push_data.rdata = mem[idx];

  always_ff @(posedge clk) begin
    if (accept && wr) mem[idx] <= merge_bytes(mem[idx], wdata, byte_mask(size, addr[1:0]));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr_q <= LFSR_SEED;
    else         lfsr_q <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
  end

  resp_queue #(
    .DEPTH   (OUTSTANDING),
    .LATENCY (LATENCY)
  ) u_resp_queue (
    .clk       (clk),
    .rst_n     (resetn),
    .push      (accept),
    .push_data (push_data),
    .pop       (data_ok),
    .head      (head),
    .head_done (head_done),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign data_ok = ~q_empty & head_done;
  assign rdata   = (data_ok && !head.wr) ? head.rdata : '0;

endmodule

// File: tb/tb_sram_like_mem_responder.sv
// Scoreboard bench: three responder instances (L2/O2, L4/O2, L2/O2 with stall),
// a per-instance expected-response queue filled on accept and drained on data_ok.
module tb_sram_like_mem_responder;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req   [3];
  logic        wr    [3];
  logic [1:0]  size  [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        addr_ok [3];
  logic        data_ok [3];

  logic        pend_use [3];
  logic [31:0] pend_exp [3];
  logic [31:0] model [3][1024];
  logic [3:0]  lfsr_m;
  exp_t        q0[$], q1[$], q2[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr_m <= 4'b1000;
    else         lfsr_m <= {lfsr_m[2:0], lfsr_m[3] ^ lfsr_m[2]};
  end

  sram_like_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2), .OUTSTANDING(2), .STALL_EN(1'b0)) dut0 (
    .clk(clk), .resetn(resetn), .req(req[0]), .wr(wr[0]), .size(size[0]), .addr(addr[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .addr_ok(addr_ok[0]), .data_ok(data_ok[0]));

  sram_like_mem_responder #(.ADDR_WIDTH(10), .LATENCY(4), .OUTSTANDING(2), .STALL_EN(1'b0)) dut1 (
    .clk(clk), .resetn(resetn), .req(req[1]), .wr(wr[1]), .size(size[1]), .addr(addr[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .addr_ok(addr_ok[1]), .data_ok(data_ok[1]));

  sram_like_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2), .OUTSTANDING(2), .STALL_EN(1'b1)) dut2 (
    .clk(clk), .resetn(resetn), .req(req[2]), .wr(wr[2]), .size(size[2]), .addr(addr[2]),
    .wdata(wdata[2]), .rdata(rdata[2]), .addr_ok(addr_ok[2]), .data_ok(data_ok[2]));

  function automatic int lat(input int k);
    return (k == 1) ? 4 : 2;
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic void qpush(input int k, input exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic exp_t qpop(input int k);
    case (k)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic int qdue(input int k);
    case (k)
      0:       return q0[0].due;
      1:       return q1[0].due;
      default: return q2[0].due;
    endcase
  endfunction

  function automatic void qflush(input int k);
    case (k)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endfunction

  function automatic logic [3:0] ref_mask(input logic [1:0] sz, input logic [1:0] off);
    if (sz == 2'b00) return 4'b0001 << off;
    if (sz == 2'b01) return off[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  // Per-instance monitor: predicts addr_ok, checks data_ok/rdata, records new accepts.
  task automatic mon(input int k);
    int          n;
    logic        exp_ok;
    exp_t        e;
    logic [9:0]  widx;
    logic [3:0]  m;
    logic [31:0] w;
    n = qsize(k);
    if (!resetn) begin
      checks++;
      if (addr_ok[k] || data_ok[k] || rdata[k] != 32'h0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d got addr_ok=%b data_ok=%b rdata=%h want 0/0/0",
                 k, addr_ok[k], data_ok[k], rdata[k]);
      end
      qflush(k);
      return;
    end
    exp_ok = req[k] && (n < 2) && (k != 2 || lfsr_m[0]);
    checks++;
    if (addr_ok[k] !== exp_ok) begin
      errors++;
      $display("FAIL addr_ok dut%0d cyc %0d got %b want %b", k, cyc, addr_ok[k], exp_ok);
    end
    if (data_ok[k]) begin
      checks++;
      if (n == 0) begin
        errors++;
        $display("FAIL spurious_data_ok dut%0d cyc %0d got data_ok=1 want 0", k, cyc);
      end else begin
        e = qpop(k);
        if (rdata[k] !== e.data || cyc != e.due) begin
          errors++;
          $display("FAIL response dut%0d got rdata %h at cyc %0d want %h at cyc %0d",
                   k, rdata[k], cyc, e.data, e.due);
        end
      end
    end else if (n > 0 && qdue(k) <= cyc) begin
      checks++;
      errors++;
      e = qpop(k);
      $display("FAIL missing_data_ok dut%0d cyc %0d got none want %h", k, cyc, e.data);
    end
    if (req[k] && addr_ok[k]) begin
      widx = addr[k][11:2];
      if (wr[k]) begin
        m = ref_mask(size[k], addr[k][1:0]);
        w = model[k][widx];
        for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = wdata[k][8*b +: 8];
        model[k][widx] = w;
        e.data = 32'h0;
      end else begin
        e.data = pend_use[k] ? pend_exp[k] : model[k][widx];
      end
      e.due = cyc + lat(k);
      qpush(k, e);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) mon(k);
  end

  // Drive one request and hold it until accepted; returns the accept cycle.
  task automatic issue(input int k, input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input logic use_exp, input logic [31:0] ex,
                       output int acc_cyc);
    int n;
    req[k] = 1'b1; wr[k] = w; size[k] = sz; addr[k] = a; wdata[k] = d;
    pend_use[k] = use_exp; pend_exp[k] = ex;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!addr_ok[k] && n < 64);
    acc_cyc = cyc;
    checks++;
    if (!addr_ok[k]) begin
      errors++;
      $display("FAIL accept_timeout dut%0d addr %h got no addr_ok want accept within 64", k, a);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    req[k] = 1'b0;
    pend_use[k] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if ((q0.size() + q1.size() + q2.size()) > 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q0.size() + q1.size() + q2.size());
    end
  endtask

  initial begin
    int c, c0, c1, c2;
    logic       rw;
    logic [1:0] rs;
    logic [3:0] rword;
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b0; wr[k] = 1'b0; size[k] = 2'b00; addr[k] = '0; wdata[k] = '0;
      pend_use[k] = 1'b0; pend_exp[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // word write then read, plus address aliasing above bit 11
    issue(0, 1'b1, 2'b10, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0, c);
    issue(0, 1'b0, 2'b10, 32'h0000_0010, 32'h0, 1'b1, 32'hDEAD_BEEF, c);
    issue(0, 1'b1, 2'b10, 32'h0000_0040, 32'h1234_5678, 1'b0, 32'h0, c);
    issue(0, 1'b0, 2'b10, 32'h0000_1040, 32'h0, 1'b1, 32'h1234_5678, c);
    idle(0);
    drain();

    // byte/half merges; reads ignore size
    issue(0, 1'b1, 2'b10, 32'h0000_0020, 32'h1122_3344, 1'b0, 32'h0, c);
    issue(0, 1'b1, 2'b00, 32'h0000_0023, 32'hAA00_0000, 1'b0, 32'h0, c);
    issue(0, 1'b1, 2'b01, 32'h0000_0020, 32'h0000_5566, 1'b0, 32'h0, c);
    issue(0, 1'b0, 2'b10, 32'h0000_0020, 32'h0, 1'b1, 32'hAA22_5566, c);
    issue(0, 1'b0, 2'b00, 32'h0000_0021, 32'h0, 1'b1, 32'hAA22_5566, c);
    issue(0, 1'b1, 2'b01, 32'h0000_0022, 32'h7788_0000, 1'b0, 32'h0, c);
    issue(0, 1'b1, 2'b00, 32'h0000_0021, 32'h0000_9900, 1'b0, 32'h0, c);
    issue(0, 1'b0, 2'b10, 32'h0000_0020, 32'h0, 1'b1, 32'h7788_9966, c);
    idle(0);
    drain();

    // back-to-back reads with req held high
    for (int i = 0; i < 4; i++)
      issue(0, 1'b1, 2'b10, 32'h100 + 32'(4 * i), 32'hA0A0_0000 + 32'(i), 1'b0, 32'h0, c);
    idle(0);
    drain();
    issue(0, 1'b0, 2'b10, 32'h0000_0100, 32'h0, 1'b1, 32'hA0A0_0000, c);
    issue(0, 1'b0, 2'b10, 32'h0000_0104, 32'h0, 1'b1, 32'hA0A0_0001, c);
    issue(0, 1'b0, 2'b10, 32'h0000_0108, 32'h0, 1'b1, 32'hA0A0_0002, c);
    issue(0, 1'b0, 2'b10, 32'h0000_010C, 32'h0, 1'b1, 32'hA0A0_0003, c);
    idle(0);
    drain();

    // full queue with LATENCY 4: third request waits out the first data_ok cycle
    issue(1, 1'b1, 2'b10, 32'h0000_0200, 32'h0BAD_F00D, 1'b0, 32'h0, c0);
    issue(1, 1'b1, 2'b10, 32'h0000_0204, 32'hCAFE_0001, 1'b0, 32'h0, c1);
    issue(1, 1'b0, 2'b10, 32'h0000_0200, 32'h0, 1'b1, 32'h0BAD_F00D, c2);
    idle(1);
    checks++;
    if (c1 != c0 + 1 || c2 != c0 + 5) begin
      errors++;
      $display("FAIL full_queue_accept got offsets %0d,%0d want 1,5", c1 - c0, c2 - c0);
    end
    drain();

    // reset one cycle after an accepted read drops its response
    issue(0, 1'b0, 2'b10, 32'h0000_0010, 32'h0, 1'b1, 32'hDEAD_BEEF, c);
    resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    idle(0);
    repeat (6) @(posedge clk);
    #1;
    issue(0, 1'b0, 2'b10, 32'h0000_0010, 32'h0, 1'b1, 32'hDEAD_BEEF, c);
    idle(0);
    drain();

    // LFSR-stalled instance: random traffic against the bench RAM model
    for (int i = 0; i < 16; i++)
      issue(2, 1'b1, 2'b10, 32'(4 * i), $urandom, 1'b0, 32'h0, c);
    for (int i = 0; i < 80; i++) begin
      rw    = 1'($urandom_range(0, 1));
      rs    = 2'($urandom_range(0, 3));
      rword = 4'($urandom_range(0, 15));
      issue(2, rw, rs, {26'h0, rword, 2'($urandom_range(0, 3))}, $urandom, 1'b0, 32'h0, c);
      if ($urandom_range(0, 3) == 0) begin
        idle(2);
        @(posedge clk);
        #1;
      end
    end
    idle(2);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
